// File: rtl/hazard_scoreboard_fwd_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
//  - RV32 major opcodes recognised by the scoreboard
//  - immediate-select codes (IMM_I .. IMM_CSR)
//  - pending-write entry layout {valid, rd, is_load}
//  - decode helpers: writes_rd / uses_rs1 / uses_rs2 / imm_code
package hazard_scoreboard_fwd_pkg;

  localparam int RD_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_CSR = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } entry_t;

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR,
      OPC_JAL, OPC_AUIPC, OPC_LUI, OPC_SYSTEM: writes_rd = 1'b1;
      default:                                 writes_rd = 1'b0;
    endcase
  endfunction

  // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field.
  function automatic logic uses_rs1(input logic [6:0] opc, input logic f3_msb);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR,
      OPC_STORE, OPC_BRANCH: uses_rs1 = 1'b1;
      OPC_SYSTEM:            uses_rs1 = ~f3_msb;
      default:               uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_code(input logic [6:0] opc);
    case (opc)
      OPC_STORE:           imm_code = IMM_S;
      OPC_BRANCH:          imm_code = IMM_B;
      OPC_LUI, OPC_AUIPC:  imm_code = IMM_U;
      OPC_JAL:             imm_code = IMM_J;
      OPC_SYSTEM:          imm_code = IMM_CSR;
      default:             imm_code = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_pending_write_pipe.sv
// Pending-write shift register for the hazard scoreboard.
//  clk, rst_n      clock, asynchronous active-low reset (entries -> invalid)
//  hold_i          freeze every stage
//  new_entry_i     entry loaded into stage 0 (caller forms bubbles)
//  valid_o         per-stage valid, bit i = stage i (0 = youngest)
//  rd_o            per-stage destination, stage i at [i*5 +: 5]
//  is_load_o       per-stage load flag
module hazard_scoreboard_fwd_pending_write_pipe
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hold_i,
  input  entry_t                         new_entry_i,
  output logic [NUM_FWD_STAGES-1:0]      valid_o,
  output logic [NUM_FWD_STAGES*RD_W-1:0] rd_o,
  output logic [NUM_FWD_STAGES-1:0]      is_load_o
);

  entry_t stage_q [NUM_FWD_STAGES];
  entry_t stage_d [NUM_FWD_STAGES];

  always_comb begin
    for (int i = 0; i < NUM_FWD_STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (!hold_i) begin
      stage_d[0] = new_entry_i;
      for (int i = 1; i < NUM_FWD_STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FWD_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FWD_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FWD_STAGES; i++) begin
      valid_o[i]              = stage_q[i].valid;
      rd_o[i*RD_W +: RD_W]    = stage_q[i].rd;
      is_load_o[i]            = stage_q[i].is_load;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// Decode-stage hazard unit: tracks in-flight register writes, drives
// operand forward selects, immediate select and branch flag, and stalls
// decode on load-use hazards.
//  clk, rst_n    clock, asynchronous active-low reset
//  dec_valid     decode holds a valid instruction
//  dec_inst      decode instruction word
//  flush         decode instruction killed this cycle
//  hold          memory stall, scoreboard frozen
//  dec_ready     decode instruction issues this cycle
//  rs1_fwd_sel   0 = regfile, k = stage NUM_FWD_STAGES-k
//  rs2_fwd_sel   as rs1_fwd_sel
//  imm_sel       0=I,1=S,2=B,3=U,4=J,5=CSR
//  is_br         conditional branch in decode
//  stall_cnt, fwd_cnt  performance counters, present only with HAZARD_PERF_EN
module hazard_scoreboard_fwd
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int LOAD_FWD_STAGE = 1,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [31:0]       dec_inst,
  input  logic              flush,
  input  logic              hold,
  output logic              dec_ready,
  output logic [SEL_W-1:0]  rs1_fwd_sel,
  output logic [SEL_W-1:0]  rs2_fwd_sel,
  output logic [2:0]        imm_sel,
  output logic              is_br
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  logic [6:0]      opc;
  logic [RD_W-1:0] rd, rs1, rs2;
  logic            use1, use2;
  logic            ld1, ld2, load_use;
  logic [NUM_FWD_STAGES-1:0]      st_valid, st_load;
  logic [NUM_FWD_STAGES*RD_W-1:0] st_rd;
  entry_t          new_entry;
  logic            unused_inst;

  assign opc = dec_inst[6:0];
  assign rd  = dec_inst[11:7];
  assign rs1 = dec_inst[19:15];
  assign rs2 = dec_inst[24:20];
  assign unused_inst = ^{dec_inst[31:25], dec_inst[13:12]};

  assign use1 = uses_rs1(opc, dec_inst[14]);
  assign use2 = uses_rs2(opc);

  // Scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    rs1_fwd_sel = '0;
    rs2_fwd_sel = '0;
    ld1 = 1'b0;
    ld2 = 1'b0;
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
      if (use1 && st_valid[i] && st_rd[i*RD_W +: RD_W] == rs1) begin
        rs1_fwd_sel = SEL_W'(NUM_FWD_STAGES - i);
        ld1 = st_load[i] && (i < LOAD_FWD_STAGE);
      end
      if (use2 && st_valid[i] && st_rd[i*RD_W +: RD_W] == rs2) begin
        rs2_fwd_sel = SEL_W'(NUM_FWD_STAGES - i);
        ld2 = st_load[i] && (i < LOAD_FWD_STAGE);
      end
    end
  end

  assign load_use  = ld1 | ld2;
  assign dec_ready = dec_valid & ~hold & ~flush & ~load_use;
  assign imm_sel   = imm_code(opc);
  assign is_br     = (opc == OPC_BRANCH);

  // x0 writes and non-issuing cycles enter the pipe as bubbles.
  always_comb begin
    new_entry.valid   = dec_ready & writes_rd(opc) & (rd != '0);
    new_entry.rd      = rd;
    new_entry.is_load = (opc == OPC_LOAD);
  end

  hazard_scoreboard_fwd_pending_write_pipe #(
    .NUM_FWD_STAGES (NUM_FWD_STAGES)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_i      (hold),
    .new_entry_i (new_entry),
    .valid_o     (st_valid),
    .rd_o        (st_rd),
    .is_load_o   (st_load)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (dec_valid && load_use && !hold) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (dec_ready && (rs1_fwd_sel != '0 || rs2_fwd_sel != '0)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
module tb_hazard_scoreboard_fwd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic        flush;
  logic        hold;
  logic        dec_ready, is_br;
  logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
  logic [2:0]  imm_sel;
  logic        dec_ready3, is_br3;
  logic [1:0]  rs1_fwd_sel3, rs2_fwd_sel3;
  logic [2:0]  imm_sel3;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, fwd_cnt, stall_cnt3, fwd_cnt3;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_fwd #(.NUM_FWD_STAGES(2), .LOAD_FWD_STAGE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .flush(flush), .hold(hold), .dec_ready(dec_ready),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .imm_sel(imm_sel), .is_br(is_br)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  hazard_scoreboard_fwd #(.NUM_FWD_STAGES(3), .LOAD_FWD_STAGE(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .flush(flush), .hold(hold), .dec_ready(dec_ready3),
    .rs1_fwd_sel(rs1_fwd_sel3), .rs2_fwd_sel(rs2_fwd_sel3),
    .imm_sel(imm_sel3), .is_br(is_br3)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic        flush;
    logic        hold;
    logic        rdy;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [2:0]  imm;
    logic        br;
  } vec_t;

  typedef struct {
    int          idx;
    logic        rdy;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [2:0]  imm;
    logic        br;
  } exp_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
    return rtype(7'd0, rs2, rs1, 3'd0, rd);
  endfunction

  function automatic logic [31:0] lw_i(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'd2, 5'(rd), 7'b0000011};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] inst, input logic fl,
                              input logic hd, input logic rdy, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [2:0] imm, input logic br);
    vec_t r;
    r.valid = v; r.inst = inst; r.flush = fl; r.hold = hd;
    r.rdy = rdy; r.s1 = s1; r.s2 = s2; r.imm = imm; r.br = br;
    return r;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      cmp("dec_ready",   e.idx, 32'(dec_ready),   32'(e.rdy));
      cmp("rs1_fwd_sel", e.idx, 32'(rs1_fwd_sel), 32'(e.s1));
      cmp("rs2_fwd_sel", e.idx, 32'(rs2_fwd_sel), 32'(e.s2));
      cmp("imm_sel",     e.idx, 32'(imm_sel),     32'(e.imm));
      cmp("is_br",       e.idx, 32'(is_br),       32'(e.br));
    end
  endtask

  // Drive one vector just after the rising edge, check at the falling edge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    dec_valid = v.valid; dec_inst = v.inst; flush = v.flush; hold = v.hold;
    e.idx = idx; e.rdy = v.rdy; e.s1 = v.s1; e.s2 = v.s2; e.imm = v.imm; e.br = v.br;
    sbq.push_back(e);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(1, add_i(5, 1, 2),                       0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[1]  = mk(1, rtype(7'h20, 5, 5, 3'd0, 6),          0, 0, 1, 2'd2, 2'd2, 3'd0, 0);
    vecs[2]  = mk(1, add_i(5, 1, 2),                       0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[3]  = mk(1, 32'h0000_0013,                        0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[4]  = mk(1, rtype(7'd0, 0, 5, 3'd6, 7),           0, 0, 1, 2'd1, 2'd0, 3'd0, 0);
    vecs[5]  = mk(1, lw_i(8, 1),                           0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[6]  = mk(1, add_i(9, 8, 0),                       0, 0, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[7]  = mk(1, add_i(9, 8, 0),                       0, 0, 1, 2'd1, 2'd0, 3'd0, 0);
    vecs[8]  = mk(1, {7'd0, 5'd3, 5'd4, 3'd2, 5'd0, 7'b0100011}, 0, 0, 1, 2'd0, 2'd0, 3'd1, 0);
    vecs[9]  = mk(1, add_i(10, 3, 3),                      0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[10] = mk(1, {7'd0, 5'd0, 5'd10, 3'd0, 5'd0, 7'b1100011}, 0, 0, 1, 2'd2, 2'd0, 3'd2, 1);
    vecs[11] = mk(1, {20'h12345, 5'd11, 7'b0110111},       0, 0, 1, 2'd0, 2'd0, 3'd3, 0);
    vecs[12] = mk(1, {20'd0, 5'd1, 7'b1101111},            0, 0, 1, 2'd0, 2'd0, 3'd4, 0);
    vecs[13] = mk(1, {12'h300, 5'd11, 3'd1, 5'd12, 7'b1110011}, 0, 0, 1, 2'd1, 2'd0, 3'd5, 0);
    vecs[14] = mk(1, {12'd0, 5'd12, 3'd0, 5'd12, 7'b0000000}, 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[15] = mk(1, add_i(13, 12, 0),                     0, 0, 1, 2'd1, 2'd0, 3'd0, 0);
    vecs[16] = mk(1, lw_i(8, 1),                           0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[17] = mk(1, add_i(9, 8, 0),                       0, 1, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[18] = mk(1, add_i(9, 8, 0),                       0, 1, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[19] = mk(1, add_i(9, 8, 0),                       0, 1, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[20] = mk(1, add_i(9, 8, 0),                       0, 0, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[21] = mk(1, add_i(9, 8, 0),                       0, 0, 1, 2'd1, 2'd0, 3'd0, 0);
    vecs[22] = mk(1, add_i(5, 1, 2),                       1, 0, 0, 2'd0, 2'd0, 3'd0, 0);
    vecs[23] = mk(1, add_i(6, 5, 5),                       0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    vecs[24] = mk(1, add_i(7, 6, 0),                       1, 1, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[25] = mk(1, add_i(7, 6, 0),                       1, 0, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[26] = mk(1, add_i(7, 6, 0),                       0, 0, 1, 2'd1, 2'd0, 3'd0, 0);
    vecs[27] = mk(0, add_i(8, 7, 0),                       0, 0, 0, 2'd2, 2'd0, 3'd0, 0);
    vecs[28] = mk(1, add_i(8, 7, 7),                       0, 0, 1, 2'd1, 2'd1, 3'd0, 0);

    // Reset state: no pending writes, decode passes straight through.
    rst_n = 1'b0; dec_valid = 1'b1; dec_inst = add_i(6, 5, 0); flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_dec_ready", -1, 32'(dec_ready), 32'd1);
    cmp("rst_rs1_sel",   -1, 32'(rs1_fwd_sel), 32'd0);
`ifdef HAZARD_PERF_EN
    cmp("rst_stall_cnt", -1, stall_cnt, 32'd0);
    cmp("rst_fwd_cnt",   -1, fwd_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(i, vecs[i]);
    end

`ifdef HAZARD_PERF_EN
    cmp("stall_cnt", NV, stall_cnt, 32'd2);
    cmp("fwd_cnt",   NV, fwd_cnt,   32'd9);
`endif

    // Asynchronous reset with x5 pending discards it immediately.
    v = mk(1, add_i(5, 1, 2), 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    apply(100, v);
    dec_inst = add_i(6, 5, 0);
    #2 cmp("pend_rs1_sel", 101, 32'(rs1_fwd_sel), 32'd2);
    rst_n = 1'b0;
    #2 cmp("async_rst_rs1_sel", 102, 32'(rs1_fwd_sel), 32'd0);
`ifdef HAZARD_PERF_EN
    cmp("async_rst_fwd_cnt", 102, fwd_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = mk(1, add_i(6, 5, 0), 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    apply(103, v);

    // Three-deep dependency: only the 3-stage build still sees x5.
    v = mk(1, add_i(5, 1, 2), 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    apply(104, v);
    v = mk(1, add_i(6, 1, 2), 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    apply(105, v);
    v = mk(1, add_i(7, 1, 2), 0, 0, 1, 2'd0, 2'd0, 3'd0, 0);
    apply(106, v);
    dec_inst = rtype(7'd0, 0, 5, 3'd6, 8);
    #2;
    cmp("deep3_rs1_sel", 107, 32'(rs1_fwd_sel3), 32'd1);
    cmp("deep3_ready",   107, 32'(dec_ready3),   32'd1);
    cmp("deep2_rs1_sel", 107, 32'(rs1_fwd_sel),  32'd0);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1);
  end

endmodule
